// File: rtl/rv32i_hazard_ctrl.sv
// rtl/rv32i_hazard_ctrl.sv - RV32I 5-stage hazard controller: forwarding, stalls, flushes, dmem wait FSM
// Forwarding or RAW interlock, load-use stall, branch flush, dmem wait-state timeout, stall counter.
module rv32i_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int FWD_EN   = 1,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcEb0,
    input  logic              PCSrcE,
    input  logic              imem_valid,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WCW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DWAIT = 2'd1;
    localparam logic [1:0] ERR   = 2'd2;

    logic [1:0]     state;
    logic [WCW-1:0] wcnt;
    logic           lu;
    logic           ms;
    logic           memWait;
    logic           inErr;

    function automatic logic regHit(input logic wr, input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

    assign memWait = dmem_req && !dmem_ack;
    assign inErr   = (state == ERR);
    assign ms      = memWait || inErr;

    always_comb begin
        lu = 1'b0;
        if (FWD_EN != 0) begin
            lu = ResultSrcEb0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        end else begin
            // Without bypass paths any in-flight writer of a decode source must drain first.
            lu = regHit(RegWriteE, RdE, Rs1D) || regHit(RegWriteE, RdE, Rs2D) ||
                 regHit(RegWriteM, RdM, Rs1D) || regHit(RegWriteM, RdM, Rs2D) ||
                 regHit(RegWriteW, RdW, Rs1D) || regHit(RegWriteW, RdW, Rs2D);
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst && (FWD_EN != 0)) begin
            if (regHit(RegWriteM, RdM, Rs1E))      ForwardAE = 2'b10;
            else if (regHit(RegWriteW, RdW, Rs1E)) ForwardAE = 2'b01;
            if (regHit(RegWriteM, RdM, Rs2E))      ForwardBE = 2'b10;
            else if (regHit(RegWriteW, RdW, Rs2E)) ForwardBE = 2'b01;
        end
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (ms) begin
            // Whole pipe freezes; a pending redirect stays in E and is taken after release.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = !inErr;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (!imem_valid) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memWait) begin
                        state <= DWAIT;
                        wcnt  <= WCW'(1);
                    end
                end
                DWAIT: begin
                    if (!memWait) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WCW'(WAIT_MAX - 1)) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                ERR: begin
                    err <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (StallF && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// tb/tb_rv32i_hazard_ctrl.sv - random and directed check of rv32i_hazard_ctrl against a reference model
module tb_rv32i_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE;
    logic       imem_valid, dmem_req, dmem_ack;

    logic [1:0]  ForwardAE_a, ForwardBE_a, ForwardAE_b, ForwardBE_b;
    logic        StallF_a, StallD_a, StallE_a, StallM_a, FlushD_a, FlushE_a, FlushW_a, err_a;
    logic        StallF_b, StallD_b, StallE_b, StallM_b, FlushD_b, FlushE_b, FlushW_b, err_b;
    logic [31:0] stall_cnt_a;
    logic [1:0]  stall_cnt_b;

    int total = 0;
    int bad   = 0;

    // per-instance model: [0] forwarding, WAIT_MAX=4, 32-bit counter; [1] interlock, WAIT_MAX=16, 2-bit counter
    int      fwdEn[2]   = '{1, 0};
    int      waitMax[2] = '{4, 16};
    longint  cntMax[2]  = '{64'hFFFF_FFFF, 64'd3};
    int      missRun[2];
    bit      errM[2];
    longint  cntM[2];

    always #5 clk = ~clk;

    rv32i_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .WAIT_MAX(4), .CNT_W(32)) dutA (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE),
        .imem_valid(imem_valid), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ForwardAE(ForwardAE_a), .ForwardBE(ForwardBE_a), .StallF(StallF_a), .StallD(StallD_a),
        .StallE(StallE_a), .StallM(StallM_a), .FlushD(FlushD_a), .FlushE(FlushE_a),
        .FlushW(FlushW_a), .err(err_a), .stall_cnt(stall_cnt_a));

    rv32i_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .WAIT_MAX(16), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE),
        .imem_valid(imem_valid), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ForwardAE(ForwardAE_b), .ForwardBE(ForwardBE_b), .StallF(StallF_b), .StallD(StallD_b),
        .StallE(StallE_b), .StallM(StallM_b), .FlushD(FlushD_b), .FlushE(FlushE_b),
        .FlushW(FlushW_b), .err(err_b), .stall_cnt(stall_cnt_b));

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit writes(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && rd != 0 && rd == rs;
    endfunction

    function automatic logic [1:0] fwdSel(input int i, input logic [4:0] rs);
        if (rst || fwdEn[i] == 0) return 2'b00;
        if (writes(RegWriteM, RdM, rs)) return 2'b10;
        if (writes(RegWriteW, RdW, rs)) return 2'b01;
        return 2'b00;
    endfunction

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [10:0] expComb(input int i);
        bit lu, ms;
        logic [6:0] ctl;
        if (fwdEn[i] != 0)
            lu = ResultSrcEb0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        else
            lu = writes(RegWriteE, RdE, Rs1D) || writes(RegWriteE, RdE, Rs2D) ||
                 writes(RegWriteM, RdM, Rs1D) || writes(RegWriteM, RdM, Rs2D) ||
                 writes(RegWriteW, RdW, Rs1D) || writes(RegWriteW, RdW, Rs2D);
        ms = (dmem_req && !dmem_ack) || errM[i];
        if (rst)              ctl = 7'b0000_111;
        else if (ms)          ctl = {4'b1111, 2'b00, !errM[i]};
        else if (PCSrcE)      ctl = 7'b0000_110;
        else if (lu)          ctl = 7'b1100_010;
        else if (!imem_valid) ctl = 7'b1000_100;
        else                  ctl = 7'b0000_000;
        return {fwdSel(i, Rs1E), fwdSel(i, Rs2E), ctl};
    endfunction

    task automatic evalCycle();
        #3;
        checkVal("combA", {ForwardAE_a, ForwardBE_a, StallF_a, StallD_a, StallE_a, StallM_a,
                           FlushD_a, FlushE_a, FlushW_a}, 64'(expComb(0)));
        checkVal("combB", {ForwardAE_b, ForwardBE_b, StallF_b, StallD_b, StallE_b, StallM_b,
                           FlushD_b, FlushE_b, FlushW_b}, 64'(expComb(1)));
        checkVal("errA", err_a, 64'(errM[0]));
        checkVal("errB", err_b, 64'(errM[1]));
        checkVal("cntA", stall_cnt_a, 64'(cntM[0]));
        checkVal("cntB", stall_cnt_b, 64'(cntM[1]));
    endtask

    task automatic advance();
        logic [10:0] e[2];
        for (int i = 0; i < 2; i++) e[i] = expComb(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                missRun[i] = 0;
                errM[i]    = 0;
                cntM[i]    = 0;
            end else begin
                if (e[i][6] && cntM[i] < cntMax[i]) cntM[i]++;
                if (!errM[i]) begin
                    missRun[i] = (dmem_req && !dmem_ack) ? missRun[i] + 1 : 0;
                    if (missRun[i] >= waitMax[i]) errM[i] = 1;
                end
            end
        end
    endtask

    task automatic cyc();
        evalCycle();
        advance();
    endtask

    task automatic idleIns();
        rst = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcEb0 = 0; PCSrcE = 0;
        imem_valid = 1; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic doReset();
        idleIns();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin missRun[i] = 0; errM[i] = 0; cntM[i] = 0; end
        idleIns();
        rst = 1;
        @(posedge clk);
        #1;
        // reset-cycle outputs and cleared registers
        evalCycle();
        checkVal("rstFlushD", FlushD_a, 1);
        checkVal("rstStallF", StallF_a, 0);
        advance();
        rst = 0;

        // forwarding priority and x0 exclusion
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5;
        evalCycle(); checkVal("fwdM", ForwardAE_a, 2'b10); advance();
        RdM = 0;
        evalCycle(); checkVal("fwdW", ForwardAE_a, 2'b01); advance();
        Rs2E = 0;
        evalCycle(); checkVal("fwdX0", ForwardBE_a, 2'b00); advance();

        // load-use, then the same with a taken branch
        idleIns();
        ResultSrcEb0 = 1; RdE = 3; RegWriteE = 1; Rs2D = 3;
        evalCycle();
        checkVal("luStallF", StallF_a, 1); checkVal("luFlushE", FlushE_a, 1);
        advance();
        PCSrcE = 1;
        evalCycle();
        checkVal("brStallF", StallF_a, 0); checkVal("brFlushD", FlushD_a, 1);
        advance();

        // three wait states then ack
        doReset();
        dmem_req = 1;
        for (int k = 0; k < 3; k++) begin
            evalCycle(); checkVal("memStallM", StallM_a, 1); checkVal("memFlushW", FlushW_a, 1); advance();
        end
        dmem_ack = 1;
        evalCycle(); checkVal("ackStallM", StallM_a, 0); advance();
        idleIns();
        evalCycle(); checkVal("memCnt", stall_cnt_a, 3); advance();

        // timeout on the WAIT_MAX=4 instance
        doReset();
        dmem_req = 1;
        for (int k = 1; k <= 7; k++) begin
            evalCycle(); checkVal("errSeq", err_a, (k >= 5) ? 1 : 0); advance();
        end
        dmem_req = 0;
        evalCycle(); checkVal("errHoldStall", StallF_a, 1); advance();
        doReset();
        evalCycle(); checkVal("errClr", err_a, 0); checkVal("cntClr", stall_cnt_a, 0); advance();

        // RAW interlock on the non-forwarding instance
        RegWriteW = 1; RdW = 7; Rs1D = 7; Rs1E = 7;
        evalCycle();
        checkVal("ilkStallD", StallD_b, 1); checkVal("ilkFlushE", FlushE_b, 1);
        checkVal("ilkFwd", ForwardAE_b, 2'b00); checkVal("ilkFwdOn", ForwardAE_a, 2'b01);
        advance();

        // fetch-invalid stall and counter saturation
        doReset();
        imem_valid = 0;
        for (int k = 0; k < 5; k++) begin
            evalCycle(); checkVal("fetchFlushD", FlushD_b, 1); advance();
        end
        imem_valid = 1;
        evalCycle(); checkVal("cntSat", stall_cnt_b, 3); advance();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            Rs1D         = 5'($urandom_range(0, 3));
            Rs2D         = 5'($urandom_range(0, 3));
            Rs1E         = 5'($urandom_range(0, 3));
            Rs2E         = 5'($urandom_range(0, 3));
            RdE          = 5'($urandom_range(0, 3));
            RdM          = 5'($urandom_range(0, 3));
            RdW          = 5'($urandom_range(0, 3));
            RegWriteE    = 1'($urandom_range(0, 1));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            ResultSrcEb0 = 1'($urandom_range(0, 1));
            PCSrcE       = ($urandom_range(0, 4) == 0);
            imem_valid   = ($urandom_range(0, 3) != 0);
            dmem_req     = 1'($urandom_range(0, 1));
            dmem_ack     = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
